// File: rtl/frame_constructor_custom_if.sv
// Port bundle for the frame constructor: 16-bit value stream in, byte-wide frame stream out.
// The slave modport is the constructor's view; the master modport is the surrounding environment.
interface frame_constructor_custom_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8
);
  logic             i_axis_TVALID;
  logic             o_axis_TREADY;
  logic [IN_W-1:0]  i_axis_TDATA;
  logic             i_axis_TLAST;
  logic             o_axis_TVALID;
  logic             i_axis_TREADY;
  logic [OUT_W-1:0] o_axis_TDATA;
  logic             o_axis_TLAST;

  modport slave (
    input  i_axis_TVALID, i_axis_TDATA, i_axis_TLAST, i_axis_TREADY,
    output o_axis_TREADY, o_axis_TVALID, o_axis_TDATA, o_axis_TLAST
  );

  modport master (
    output i_axis_TVALID, i_axis_TDATA, i_axis_TLAST, i_axis_TREADY,
    input  o_axis_TREADY, o_axis_TVALID, o_axis_TDATA, o_axis_TLAST
  );
endinterface

// File: rtl/frame_constructor_custom.sv
// Buffers one packet of 16-bit values, then emits DEST/SRC MAC, big-endian length,
// payload bytes MSB-first and an optional in-band end-of-stream marker, one byte per beat.
module frame_constructor_custom #(
  parameter int          INPUT_VALUE_WIDTH      = 16,
  parameter int          INPUT_AXIS_DATA_WIDTH  = 8*((INPUT_VALUE_WIDTH-1)/8+1),
  parameter int          OUTPUT_AXIS_DATA_WIDTH = 8,
  parameter int          MAX_PAYLOAD_VALUES     = 64,
  parameter logic [47:0] DEST_MAC               = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] SRC_MAC                = 48'h000A35000001,
  parameter logic [15:0] TLAST_MARKER           = 16'h03FF
) (
  input  logic                      i_clk,
  input  logic                      i_areset,
  frame_constructor_custom_if.slave bus
);
  localparam int          AW  = $clog2(MAX_PAYLOAD_VALUES);
  localparam int          NW  = AW + 1;
  localparam logic [95:0] HDR = {DEST_MAC, SRC_MAC};

  typedef enum logic [2:0] {S_FILL, S_HDR, S_LEN, S_DATA, S_MARK} state_e;

  state_e                            state_q, state_d;
  logic [NW-1:0]                     cnt_q, cnt_d;
  logic                              mark_q, mark_d;
  logic [15:0]                       idx_q, idx_d;
  logic                              tready_q, tready_d;
  logic                              tvalid_q, tvalid_d;
  logic [OUTPUT_AXIS_DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                              tlast_q, tlast_d;
  logic [15:0]                       mem_q [MAX_PAYLOAD_VALUES];

  logic [INPUT_AXIS_DATA_WIDTH-1:0]  in_data;
  logic [15:0]                       wr_data, rd_val, len, data_end;
  logic [95:0]                       hdr_sh;
  logic                              wr_en, in_hs, out_hs;

  assign in_data  = bus.i_axis_TDATA;
  assign in_hs    = tready_q && bus.i_axis_TVALID;
  assign out_hs   = tvalid_q && bus.i_axis_TREADY;
  assign len      = 16'({cnt_q, 1'b0}) + 16'({mark_q, 1'b0});
  assign data_end = 16'({cnt_q, 1'b0}) - 16'd1;

  // NOTE: combinational blocks use blocking '=' and assign every output a default
  // first, so no path through the block can leave a latch behind.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mark_d  = mark_q;
    idx_d   = idx_q;
    wr_en   = 1'b0;
    wr_data = '0;
    wr_data[INPUT_VALUE_WIDTH-1:0] = in_data[INPUT_VALUE_WIDTH-1:0];

    unique case (state_q)
      S_FILL: if (in_hs) begin
        wr_en = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (bus.i_axis_TLAST) begin
          mark_d  = 1'b1;
          state_d = S_HDR;
          idx_d   = '0;
        end else if (cnt_d == NW'(MAX_PAYLOAD_VALUES)) begin
          state_d = S_HDR;
          idx_d   = '0;
        end
      end
      S_HDR: if (out_hs) begin
        if (idx_q == 16'd11) begin
          state_d = S_LEN;
          idx_d   = '0;
        end else idx_d = idx_q + 16'd1;
      end
      S_LEN: if (out_hs) begin
        if (idx_q == 16'd1) begin
          state_d = S_DATA;
          idx_d   = '0;
        end else idx_d = idx_q + 16'd1;
      end
      S_DATA: if (out_hs) begin
        if (idx_q == data_end) begin
          idx_d = '0;
          if (mark_q) state_d = S_MARK;
          else begin
            state_d = S_FILL;
            cnt_d   = '0;
            mark_d  = 1'b0;
          end
        end else idx_d = idx_q + 16'd1;
      end
      S_MARK: if (out_hs) begin
        if (idx_q == 16'd1) begin
          state_d = S_FILL;
          idx_d   = '0;
          cnt_d   = '0;
          mark_d  = 1'b0;
        end else idx_d = idx_q + 16'd1;
      end
      default: state_d = S_FILL;
    endcase

    // Outputs are registered: compute the byte the next state will present.
    hdr_sh   = HDR << {idx_d[3:0], 3'b000};
    rd_val   = mem_q[idx_d[AW:1]];
    tready_d = (state_d == S_FILL);
    tvalid_d = !tready_d;
    unique case (state_d)
      S_HDR:   tdata_d = hdr_sh[95:88];
      S_LEN:   tdata_d = idx_d[0] ? len[7:0] : len[15:8];
      S_DATA:  tdata_d = idx_d[0] ? rd_val[7:0] : rd_val[15:8];
      S_MARK:  tdata_d = idx_d[0] ? TLAST_MARKER[7:0] : TLAST_MARKER[15:8];
      default: tdata_d = '0;
    endcase
    tlast_d = ((state_d == S_DATA) && (idx_d == data_end) && !mark_q) ||
              ((state_d == S_MARK) && (idx_d == 16'd1));
  end

  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      state_q  <= S_FILL;
      cnt_q    <= '0;
      mark_q   <= 1'b0;
      idx_q    <= '0;
      tready_q <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mark_q   <= mark_d;
      idx_q    <= idx_d;
      tready_q <= tready_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
    end
  end

  // NOTE: the payload buffer has no reset; every entry read out was written during the
  // current fill, so clearing it would only cost logic.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[cnt_q[AW-1:0]] <= wr_data;
  end

  assign bus.o_axis_TREADY = tready_q;
  assign bus.o_axis_TVALID = tvalid_q;
  assign bus.o_axis_TDATA  = tdata_q;
  assign bus.o_axis_TLAST  = tlast_q;
endmodule

// File: tb/tb_frame_constructor_custom.sv
// Directed bench for frame_constructor_custom: fills packets, drains frames under
// several TREADY patterns and compares every byte against expected frames.
module tb_frame_constructor_custom;
  logic i_clk = 1'b0;
  logic i_areset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc;

  logic [7:0]  exp_q[$];
  logic [15:0] val_q[$];

  frame_constructor_custom_if #(.IN_W(16), .OUT_W(8)) bus();

  frame_constructor_custom dut (
    .i_clk    (i_clk),
    .i_areset (i_areset),
    .bus      (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_val(input logic [15:0] v, input logic last);
    int w;
    w = 0;
    bus.i_axis_TVALID = 1'b1;
    bus.i_axis_TDATA  = v;
    bus.i_axis_TLAST  = last;
    while (bus.o_axis_TREADY !== 1'b1 && w < 100) begin
      tick();
      w++;
    end
    check("in_ready", 16'(bus.o_axis_TREADY), 16'd1);
    tick();
    bus.i_axis_TVALID = 1'b0;
    bus.i_axis_TLAST  = 1'b0;
  endtask

  // Expected frame from val_q: header, length, payload, optional marker.
  task automatic build_exp(input bit m);
    logic [95:0] hdr;
    logic [15:0] l;
    hdr = {48'hFFFFFFFFFFFF, 48'h000A35000001};
    exp_q.delete();
    for (int i = 0; i < 12; i++) exp_q.push_back(hdr[95-8*i -: 8]);
    l = 16'(2*val_q.size()) + (m ? 16'd2 : 16'd0);
    exp_q.push_back(l[15:8]);
    exp_q.push_back(l[7:0]);
    foreach (val_q[i]) begin
      exp_q.push_back(val_q[i][15:8]);
      exp_q.push_back(val_q[i][7:0]);
    end
    if (m) begin
      exp_q.push_back(8'h03);
      exp_q.push_back(8'hFF);
    end
  endtask

  // Drain exp_q (or its first stop_after bytes) with TREADY following pat[k%4].
  task automatic collect(input logic [3:0] pat, input int stop_after, output int cycles);
    int idx, k, n;
    logic [7:0] hd;
    logic hl, held, rdy;
    idx = 0; k = 0; held = 1'b0; hd = '0; hl = 1'b0;
    n = (stop_after > 0) ? stop_after : exp_q.size();
    while (idx < n && k < 4000) begin
      check("out_valid", 16'(bus.o_axis_TVALID), 16'd1);
      check("in_stalled", 16'(bus.o_axis_TREADY), 16'd0);
      if (held) begin
        check("hold_data", 16'(bus.o_axis_TDATA), 16'(hd));
        check("hold_last", 16'(bus.o_axis_TLAST), 16'(hl));
      end
      rdy = pat[k[1:0]];
      bus.i_axis_TREADY = rdy;
      if (rdy) begin
        check($sformatf("byte%0d", idx), 16'(bus.o_axis_TDATA), 16'(exp_q[idx]));
        check($sformatf("last%0d", idx), 16'(bus.o_axis_TLAST),
              16'(idx == exp_q.size() - 1));
        idx++;
        held = 1'b0;
      end else begin
        hd   = bus.o_axis_TDATA;
        hl   = bus.o_axis_TLAST;
        held = 1'b1;
      end
      tick();
      k++;
    end
    bus.i_axis_TREADY = 1'b0;
    check("collect_done", 16'(idx), 16'(n));
    cycles = k;
    if (stop_after == 0) begin
      check("turn_ready", 16'(bus.o_axis_TREADY), 16'd1);
      check("turn_valid", 16'(bus.o_axis_TVALID), 16'd0);
    end
  endtask

  initial begin
    bus.i_axis_TVALID = 1'b0;
    bus.i_axis_TDATA  = '0;
    bus.i_axis_TLAST  = 1'b0;
    bus.i_axis_TREADY = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_tready", 16'(bus.o_axis_TREADY), 16'd0);
    check("rst_tvalid", 16'(bus.o_axis_TVALID), 16'd0);
    check("rst_tdata",  16'(bus.o_axis_TDATA),  16'd0);
    check("rst_tlast",  16'(bus.o_axis_TLAST),  16'd0);
    i_areset = 1'b0;
    tick();
    check("post_rst_tready", 16'(bus.o_axis_TREADY), 16'd1);
    check("post_rst_tvalid", 16'(bus.o_axis_TVALID), 16'd0);

    // Scenario 1: three values with TLAST, continuous TREADY
    exp_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
              8'h00, 8'h0A, 8'h35, 8'h00, 8'h00, 8'h01,
              8'h00, 8'h08, 8'h12, 8'h34, 8'h00, 8'h05, 8'hAB, 8'hCD,
              8'h03, 8'hFF};
    send_val(16'h1234, 1'b0);
    send_val(16'h0005, 1'b0);
    send_val(16'hABCD, 1'b1);
    collect(4'b1111, 0, cyc);
    check("s1_cycles", 16'(cyc), 16'd22);

    // Scenario 1 again under TREADY pattern 1,0,0,1
    send_val(16'h1234, 1'b0);
    send_val(16'h0005, 1'b0);
    send_val(16'hABCD, 1'b1);
    collect(4'b1001, 0, cyc);
    check("bp_cycles", 16'(cyc), 16'd44);

    // 65 values: full chunk without marker, 65th stalls until the chunk is out
    val_q.delete();
    for (int i = 1; i <= 64; i++) begin
      val_q.push_back(16'(i));
      send_val(16'(i), 1'b0);
    end
    build_exp(1'b0);
    check("chunk_len", {exp_q[12], exp_q[13]}, 16'h0080);
    bus.i_axis_TVALID = 1'b1;
    bus.i_axis_TDATA  = 16'h0041;
    bus.i_axis_TLAST  = 1'b1;
    collect(4'b1111, 0, cyc);
    check("chunk_cycles", 16'(cyc), 16'd142);
    tick();
    bus.i_axis_TVALID = 1'b0;
    bus.i_axis_TLAST  = 1'b0;
    exp_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
              8'h00, 8'h0A, 8'h35, 8'h00, 8'h00, 8'h01,
              8'h00, 8'h04, 8'h00, 8'h41, 8'h03, 8'hFF};
    collect(4'b1111, 0, cyc);
    check("tail_cycles", 16'(cyc), 16'd18);

    // 64 values with TLAST on the 64th: marker present
    val_q.delete();
    for (int i = 1; i <= 64; i++) begin
      val_q.push_back(16'(i));
      send_val(16'(i), i == 64);
    end
    build_exp(1'b1);
    check("full_len", {exp_q[12], exp_q[13]}, 16'h0082);
    collect(4'b1111, 0, cyc);
    check("full_cycles", 16'(cyc), 16'd144);

    // Reset during payload after three data bytes
    exp_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
              8'h00, 8'h0A, 8'h35, 8'h00, 8'h00, 8'h01,
              8'h00, 8'h08, 8'h12, 8'h34, 8'h00, 8'h05, 8'hAB, 8'hCD,
              8'h03, 8'hFF};
    send_val(16'h1234, 1'b0);
    send_val(16'h0005, 1'b0);
    send_val(16'hABCD, 1'b1);
    collect(4'b1111, 17, cyc);
    i_areset = 1'b1;
    tick();
    check("mid_rst_tvalid", 16'(bus.o_axis_TVALID), 16'd0);
    check("mid_rst_tlast",  16'(bus.o_axis_TLAST),  16'd0);
    i_areset = 1'b0;
    tick();
    check("mid_rst_tready", 16'(bus.o_axis_TREADY), 16'd1);
    check("mid_rst_tvalid2", 16'(bus.o_axis_TVALID), 16'd0);
    exp_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
              8'h00, 8'h0A, 8'h35, 8'h00, 8'h00, 8'h01,
              8'h00, 8'h04, 8'h00, 8'hAA, 8'h03, 8'hFF};
    send_val(16'h00AA, 1'b1);
    collect(4'b1111, 0, cyc);
    check("clean_cycles", 16'(cyc), 16'd18);

    // Input gaps during fill do not affect the frame
    val_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int i = 0; i < 4; i++) begin
      send_val(val_q[i], i == 3);
      if (i < 3) begin
        tick();
        check("gap_ready", 16'(bus.o_axis_TREADY), 16'd1);
      end
    end
    build_exp(1'b1);
    check("gap_len", {exp_q[12], exp_q[13]}, 16'h000A);
    collect(4'b1111, 0, cyc);
    check("gap_cycles", 16'(cyc), 16'd24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/frame_constructor_custom.md
# frame_constructor_custom

Transmit-side framing stage. It accepts 16-bit values from the compression core on a slave AXI-Stream and buffers one packet's worth. It then emits a byte-wide frame on a master AXI-Stream toward the TEMAC TX path: 6-byte destination address, 6-byte source address, 2-byte big-endian payload length, payload bytes MSB-first, and an in-band end-of-stream marker. The frame layout is exactly the one the receive-side frame destructor parses, so constructor output can be looped directly into it.

## Interface
- INPUT_VALUE_WIDTH, 16, width of each input value (≤16; zero-extended to 16 bits).
- INPUT_AXIS_DATA_WIDTH, 8*((INPUT_VALUE_WIDTH-1)/8+1), input TDATA width.
- OUTPUT_AXIS_DATA_WIDTH, 8, output TDATA width (one byte per beat).
- MAX_PAYLOAD_VALUES, 64, buffer depth in values (power of 2, 2..1024).
- DEST_MAC, 48'hFFFFFFFFFFFF, destination address, sent MSB byte first.
- SRC_MAC, 48'h000A35000001, source address, sent MSB byte first.
- TLAST_MARKER, 16'h03FF, in-band end-of-stream value.
- i_clk  in  1  single clock for both interfaces.
- i_areset  in  1  **synchronous, active-high** reset.
- i_axis_TVALID  in  1  input value valid.
- o_axis_TREADY  out  1  input ready.
- i_axis_TDATA  in  INPUT_AXIS_DATA_WIDTH  input value.
- i_axis_TLAST  in  1  last value of the compressed stream.
- o_axis_TVALID  out  1  output byte valid.
- i_axis_TREADY  in  1  TEMAC-side ready.
- o_axis_TDATA  out  OUTPUT_AXIS_DATA_WIDTH  output byte.
- o_axis_TLAST  out  1  last byte of frame.

## Operation
- States: S_FILL, S_HDR, S_LEN, S_DATA, S_MARK.
- S_FILL:
  - o_axis_TREADY=1 and o_axis_TVALID=0.
  - Each input handshake writes the value to buffer[N] and increments N.
  - Fill ends on a handshake with TLAST=1, which sets flag m=1.
  - Fill also ends on a handshake that makes N==MAX_PAYLOAD_VALUES with TLAST=0, which leaves m=0 (chunked frame, no marker).
  - Either way, the next state is S_HDR.
- S_HDR: 12 bytes, DEST_MAC[47:40] first through SRC_MAC[7:0].
- S_LEN: 2 bytes, L[15:8] then L[7:0], where L = 2*N + 2*m (bytes following the length field).
- S_DATA: 2*N bytes; for each value, bits [15:8] then [7:0], in arrival order.
- S_MARK (only if m=1): TLAST_MARKER[15:8], then [7:0].
- o_axis_TLAST=1 only on the final byte of the frame: marker low byte if m=1, otherwise the last data byte.
- After that byte's handshake: state returns to S_FILL, and N and m clear.
- o_axis_TREADY=0 and o_axis_TVALID=1 throughout S_HDR, S_LEN, S_DATA and S_MARK.
- Byte counters advance only on an output handshake (o_axis_TVALID && i_axis_TREADY).
- Payload values 0x0000 and TLAST_MARKER are passed unmodified; no escaping. They are reserved by the downstream destructor, and the compression core never produces them.
- N ≥ 1 in every frame, so empty frames are never emitted.
- Widths: N is $clog2(MAX_PAYLOAD_VALUES)+1 bits; L is 16 bits. Frame length is 14 + L bytes, maximum 14 + 2*MAX+2.

## Timing
- Reset, while i_areset=1 at a clock edge:
  - state=S_FILL, N=0, m=0.
  - All outputs read 0: o_axis_TREADY, o_axis_TVALID, o_axis_TDATA, o_axis_TLAST.
  - o_axis_TREADY rises in the first cycle after i_areset deasserts.
- Reset mid-frame (any state):
  - Buffered data is dropped and the partial frame is abandoned.
  - No TLAST is issued.
  - o_axis_TVALID is 0 from the cycle after the reset edge.
- Input: one value per cycle in S_FILL. Values are sampled only when TVALID && TREADY.
- Latency: final input handshake at edge t gives o_axis_TVALID=1 with DEST_MAC[47:40] in cycle t+1.
- Output throughput: with i_axis_TREADY held 1, one byte per cycle and a frame in exactly 14+L cycles.
- Backpressure: while o_axis_TVALID=1 and i_axis_TREADY=0, o_axis_TDATA and o_axis_TLAST hold stable. o_axis_TVALID never drops mid-frame.
- Turnaround: TLAST byte handshake at edge t gives o_axis_TREADY=1 in cycle t+1 (no idle gap beyond that).
- Input beats presented during S_HDR..S_MARK stall (TREADY=0); none are dropped.

## Test plan
- 3 values 0x1234, 0x0005, 0xABCD, TLAST on third, TREADY=1 → 22 bytes: FF×6, 00 0A 35 00 00 01, 00 08, 12 34 00 05 AB CD, 03 FF with TLAST on final FF. First byte one cycle after last input handshake.
- 65 values (0x0001..0x0041), TLAST on 65th → frame 1: length 0x0080, 142 bytes, no marker, TLAST on byte 0x40. Frame 2: length 0x0004, bytes 00 41 03 FF.
- 64 values with TLAST on the 64th → single frame, length 0x0082, 144 bytes, marker present.
- Output backpressure: i_axis_TREADY pattern 1,0,0,1 repeating during scenario 1 → byte sequence identical, TDATA/TLAST stable during each stall, frame duration extended accordingly.
- Reset asserted for 1 cycle in S_DATA after 3 payload bytes → TVALID=0 next cycle, no TLAST seen. A following 1-value packet 0x00AA with TLAST yields a clean 18-byte frame with length 0x0004.
- Input stall: i_axis_TVALID toggling 1,0 during fill of 4 values → frame contents and length 0x000A unaffected by input gaps.
